// File: rtl/serial_add4_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and default operand width.
package serial_add4_pkg;
  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;
endpackage

// File: rtl/serial_add4_fa.sv
// Single-bit full-adder cell used once by the serial adder datapath.
module fa (
  output logic s,
  output logic co,
  input  logic a,
  input  logic b,
  input  logic ci
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_add4.sv
// Bit-serial adder: one full-adder cell per cycle, LSB first, WIDTH cycles per sum.
module serial_add4
  import serial_add4_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
);
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, acc;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             cell_s, cell_co;
  logic             load, last;

  fa u_fa (
    .s  (cell_s),
    .co (cell_co),
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: if (start) begin load = 1'b1; state_nxt = RUN; end
      RUN:  if (last) state_nxt = DONE;
      DONE: begin
        if (start) begin load = 1'b1; state_nxt = RUN; end
        else state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
    end
  end

  // acc collects sum bits from the MSB side; s/co only see it on the final RUN edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sr  <= '0;
      b_sr  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      co    <= 1'b0;
    end else if (load) begin
      a_sr  <= a;
      b_sr  <= b;
      acc   <= '0;
      carry <= ci;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      acc   <= {cell_s, acc[WIDTH-1:1]};
      carry <= cell_co;
      cnt   <= cnt + CW'(1);
      if (last) begin
        s  <= {cell_s, acc[WIDTH-1:1]};
        co <= cell_co;
      end
    end
  end
endmodule
